pc_trace_monitor: RTL and testbench

PC_TRACE_MONITOR -- requirements
Module: pc_trace_monitor

---
 rtl/cpu_dbg_pkg.sv | 18 +
 rtl/trace_ring.sv | 46 ++++
 rtl/pc_trace_monitor.sv | 133 +++++++++++++
 tb/tb_pc_trace_monitor.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_dbg_pkg.sv
// Shared debug-unit types: monitor FSM encoding and status flag layout.
package cpu_dbg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int FLAG_W        = 4;
  localparam int FLAG_DONE     = 0;
  localparam int FLAG_TIMEOUT  = 1;
  localparam int FLAG_HALTED   = 2;
  localparam int FLAG_OVERFLOW = 3;

  typedef logic [FLAG_W-1:0] flags_t;

endpackage

// File: rtl/trace_ring.sv
// Circular PC trace store; read index 0 is the oldest held entry.
module trace_ring #(
  parameter int W     = 32,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          we,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] rd_idx,
  output logic [W-1:0]  rd_data,
  output logic [AW:0]   cnt,
  output logic          full
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] base;

  assign full = cnt == (AW+1)'(DEPTH);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr <= '0;
      cnt  <= '0;
    end else if (clr) begin
      wptr <= '0;
      cnt  <= '0;
    end else if (we) begin
      wptr <= wptr + 1'b1;
      if (!full) cnt <= cnt + 1'b1;
    end
  end

  // storage is never reset; cnt alone says what is valid
  always_ff @(posedge clk) begin
    if (we) mem[wptr] <= wdata;
  end

  // once full, the oldest entry sits at the write pointer
  assign base    = full ? wptr : '0;
  assign rd_data = mem[base + rd_idx];

endmodule

// File: rtl/pc_trace_monitor.sv
// Non-intrusive PC tracer with stall, breakpoint and cycle-budget stop.
module pc_trace_monitor
  import cpu_dbg_pkg::*;
#(
  parameter int PC_WIDTH    = 32,
  parameter int DEPTH       = 16,
  parameter int MAX_CYCLES  = 10,
  parameter int STALL_LIMIT = 4,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [PC_WIDTH-1:0] pc,
  input  logic [PC_WIDTH-1:0] halt_addr,
  input  logic                halt_addr_en,
  input  logic [AW-1:0]       rd_idx,
  output logic [PC_WIDTH-1:0] rd_data,
  output logic                rd_valid,
  output logic [31:0]         cycle_cnt,
  output logic [AW:0]         trace_cnt,
  output logic                done,
  output logic                timeout,
  output logic                halted,
  output logic                overflow
);

  state_t              state, state_n;
  flags_t              flags, flags_n;
  logic [31:0]         cyc, cyc_n;
  logic [31:0]         stall, stall_n;
  logic [PC_WIDTH-1:0] prev, prev_n;
  logic                primed, primed_n;
  logic                rep, clr, we, full;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      flags  <= '0;
      cyc    <= '0;
      stall  <= '0;
      prev   <= '0;
      primed <= 1'b0;
    end else begin
      state  <= state_n;
      flags  <= flags_n;
      cyc    <= cyc_n;
      stall  <= stall_n;
      prev   <= prev_n;
      primed <= primed_n;
    end
  end

  always_comb begin
    state_n  = state;
    flags_n  = flags;
    cyc_n    = cyc;
    stall_n  = stall;
    prev_n   = prev;
    primed_n = primed;
    rep      = 1'b0;
    clr      = 1'b0;
    we       = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (en) begin
          state_n  = ST_RUN;
          flags_n  = '0;
          cyc_n    = '0;
          stall_n  = '0;
          primed_n = 1'b0;
          clr      = 1'b1;
        end
      end
      ST_RUN: begin
        if (!en) begin
          state_n = ST_IDLE;
          flags_n = '0;
        end else begin
          cyc_n    = (&cyc) ? cyc : cyc + 32'd1;
          // previous sample always equals the last written entry
          rep      = primed && (pc == prev);
          we       = !rep;
          stall_n  = rep ? stall + 32'd1 : 32'd0;
          prev_n   = pc;
          primed_n = 1'b1;
          if (we && full)
            flags_n[FLAG_OVERFLOW] = 1'b1;
          if (stall_n >= 32'(STALL_LIMIT - 1))
            flags_n[FLAG_HALTED] = 1'b1;
          if (halt_addr_en && pc == halt_addr)
            flags_n[FLAG_HALTED] = 1'b1;
          if (cyc_n >= 32'(MAX_CYCLES))
            flags_n[FLAG_TIMEOUT] = 1'b1;
          if (flags_n[FLAG_HALTED] || flags_n[FLAG_TIMEOUT]) begin
            flags_n[FLAG_DONE] = 1'b1;
            state_n            = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (!en) begin
          state_n = ST_IDLE;
          flags_n = '0;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  trace_ring #(
    .W     (PC_WIDTH),
    .DEPTH (DEPTH)
  ) u_ring (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr),
    .we      (we),
    .wdata   (pc),
    .rd_idx  (rd_idx),
    .rd_data (rd_data),
    .cnt     (trace_cnt),
    .full    (full)
  );

  assign rd_valid  = {1'b0, rd_idx} < trace_cnt;
  assign cycle_cnt = cyc;
  assign done      = flags[FLAG_DONE];
  assign timeout   = flags[FLAG_TIMEOUT];
  assign halted    = flags[FLAG_HALTED];
  assign overflow  = flags[FLAG_OVERFLOW];

endmodule

// File: tb/tb_pc_trace_monitor.sv
// Bench for pc_trace_monitor: vector table, directed corners, random vs model.
module tb_pc_trace_monitor;

  localparam int STALL = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        hae = 1'b0;
  logic [31:0] pc = '0;
  logic [31:0] ha = '0;
  logic [3:0]  rd_idx = '0;

  logic [31:0] a_rd, b_rd, a_cyc, b_cyc;
  logic        a_rv, b_rv, a_dn, b_dn, a_to, b_to;
  logic        a_h, b_h, a_ov, b_ov;
  logic [4:0]  a_tc;
  logic [2:0]  b_tc;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pc_trace_monitor u_a (
    .clk(clk), .rst_n(rst_n), .en(en), .pc(pc),
    .halt_addr(ha), .halt_addr_en(hae), .rd_idx(rd_idx),
    .rd_data(a_rd), .rd_valid(a_rv), .cycle_cnt(a_cyc),
    .trace_cnt(a_tc), .done(a_dn), .timeout(a_to),
    .halted(a_h), .overflow(a_ov)
  );

  pc_trace_monitor #(.DEPTH(4), .MAX_CYCLES(20)) u_b (
    .clk(clk), .rst_n(rst_n), .en(en), .pc(pc),
    .halt_addr(ha), .halt_addr_en(hae), .rd_idx(rd_idx[1:0]),
    .rd_data(b_rd), .rd_valid(b_rv), .cycle_cnt(b_cyc),
    .trace_cnt(b_tc), .done(b_dn), .timeout(b_to),
    .halted(b_h), .overflow(b_ov)
  );

  // reference model: mode 0 idle, 1 running, 2 stopped
  int          mode [2];
  int          mcyc [2];
  int          ns [2];
  int          nd [2];
  bit          mdn [2], mto [2], mh [2], mov [2];
  logic [31:0] smp [2][64];
  logic [31:0] dl [2][64];

  function automatic int dep(input int k);
    return (k == 0) ? 16 : 4;
  endfunction

  function automatic int maxc(input int k);
    return (k == 0) ? 10 : 20;
  endfunction

  task automatic mclr(input int k);
    mdn[k] = 0; mto[k] = 0; mh[k] = 0; mov[k] = 0;
  endtask

  task automatic mstep(input int k);
    bit stl;
    if (!rst_n) begin
      mode[k] = 0; mcyc[k] = 0; ns[k] = 0; nd[k] = 0;
      mclr(k);
    end else if (mode[k] == 0) begin
      if (en) begin
        mode[k] = 1; mcyc[k] = 0; ns[k] = 0; nd[k] = 0;
        mclr(k);
      end
    end else if (!en) begin
      mode[k] = 0;
      mclr(k);
    end else if (mode[k] == 1) begin
      if (nd[k] == 0 || dl[k][nd[k]-1] != pc) begin
        dl[k][nd[k]] = pc;
        nd[k]++;
      end
      smp[k][ns[k]] = pc;
      ns[k]++;
      mcyc[k]++;
      mov[k] = nd[k] > dep(k);
      stl = ns[k] >= STALL;
      if (stl)
        for (int i = 1; i < STALL; i++)
          if (smp[k][ns[k]-1-i] != pc) stl = 0;
      mh[k]  = stl || (hae && pc == ha);
      mto[k] = mcyc[k] >= maxc(k);
      if (mh[k] || mto[k]) begin
        mdn[k]  = 1;
        mode[k] = 2;
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    mstep(0);
    mstep(1);
    #1;
  endtask

  task automatic cmp(input int k);
    int v, idx;
    string p;
    p   = (k == 0) ? "a" : "b";
    v   = (nd[k] < dep(k)) ? nd[k] : dep(k);
    idx = (k == 0) ? int'(rd_idx) : int'(rd_idx[1:0]);
    chk({p, "_cycle"}, k == 0 ? a_cyc : b_cyc, 32'(mcyc[k]));
    chk({p, "_tcnt"}, k == 0 ? 32'(a_tc) : 32'(b_tc), 32'(v));
    chk({p, "_done"}, 32'(k == 0 ? a_dn : b_dn), 32'(mdn[k]));
    chk({p, "_tmo"}, 32'(k == 0 ? a_to : b_to), 32'(mto[k]));
    chk({p, "_halt"}, 32'(k == 0 ? a_h : b_h), 32'(mh[k]));
    chk({p, "_ovf"}, 32'(k == 0 ? a_ov : b_ov), 32'(mov[k]));
    chk({p, "_rv"}, 32'(k == 0 ? a_rv : b_rv), 32'(idx < v));
    if (idx < v)
      chk({p, "_rd"}, k == 0 ? a_rd : b_rd, dl[k][nd[k]-v+idx]);
  endtask

  task automatic arm();
    rst_n = 0; en = 0; hae = 0;
    tick();
    rst_n = 1; en = 1;
    tick();
  endtask

  typedef struct {
    logic        r, e, h;
    logic [31:0] p, a;
    int          cyc, tc;
    logic        dn, hl, to;
  } vec_t;

  vec_t tv[17];

  function automatic vec_t mk(logic r, logic e, logic h, logic [31:0] p,
                              logic [31:0] a, int cyc, int tc,
                              logic dn, logic hl, logic to);
    vec_t v;
    v.r = r; v.e = e; v.h = h; v.p = p; v.a = a;
    v.cyc = cyc; v.tc = tc; v.dn = dn; v.hl = hl; v.to = to;
    return v;
  endfunction

  initial begin
    // breakpoint at 0x10, then stall on 0xC (instance a)
    tv[0]  = mk(0, 0, 0, 'h00, 'h00, 0, 0, 0, 0, 0);
    tv[1]  = mk(1, 1, 1, 'h00, 'h10, 0, 0, 0, 0, 0);
    tv[2]  = mk(1, 1, 1, 'h00, 'h10, 1, 1, 0, 0, 0);
    tv[3]  = mk(1, 1, 1, 'h04, 'h10, 2, 2, 0, 0, 0);
    tv[4]  = mk(1, 1, 1, 'h08, 'h10, 3, 3, 0, 0, 0);
    tv[5]  = mk(1, 1, 1, 'h0C, 'h10, 4, 4, 0, 0, 0);
    tv[6]  = mk(1, 1, 1, 'h10, 'h10, 5, 5, 1, 1, 0);
    tv[7]  = mk(1, 1, 1, 'h14, 'h10, 5, 5, 1, 1, 0);
    tv[8]  = mk(0, 0, 0, 'h00, 'h00, 0, 0, 0, 0, 0);
    tv[9]  = mk(1, 1, 0, 'h00, 'h00, 0, 0, 0, 0, 0);
    tv[10] = mk(1, 1, 0, 'h00, 'h00, 1, 1, 0, 0, 0);
    tv[11] = mk(1, 1, 0, 'h04, 'h00, 2, 2, 0, 0, 0);
    tv[12] = mk(1, 1, 0, 'h08, 'h00, 3, 3, 0, 0, 0);
    tv[13] = mk(1, 1, 0, 'h0C, 'h00, 4, 4, 0, 0, 0);
    tv[14] = mk(1, 1, 0, 'h0C, 'h00, 5, 4, 0, 0, 0);
    tv[15] = mk(1, 1, 0, 'h0C, 'h00, 6, 4, 0, 0, 0);
    tv[16] = mk(1, 1, 0, 'h0C, 'h00, 7, 4, 1, 1, 0);

    rst_n = 0;
    tick();
    tick();
    chk("rst_cycle", a_cyc, 0);
    chk("rst_tcnt", 32'(a_tc), 0);
    chk("rst_rv", 32'(a_rv), 0);
    chk("rst_flags", {28'd0, a_dn, a_to, a_h, a_ov}, 0);

    for (int i = 0; i < 17; i++) begin
      rst_n = tv[i].r; en = tv[i].e; hae = tv[i].h;
      pc = tv[i].p; ha = tv[i].a;
      tick();
      chk($sformatf("v%0d_cycle", i), a_cyc, 32'(tv[i].cyc));
      chk($sformatf("v%0d_tcnt", i), 32'(a_tc), 32'(tv[i].tc));
      chk($sformatf("v%0d_done", i), 32'(a_dn), 32'(tv[i].dn));
      chk($sformatf("v%0d_halt", i), 32'(a_h), 32'(tv[i].hl));
      chk($sformatf("v%0d_tmo", i), 32'(a_to), 32'(tv[i].to));
    end
    for (int i = 0; i < 4; i++) begin
      rd_idx = 4'(i);
      #1 chk($sformatf("stall_rd%0d", i), a_rd, 32'(4 * i));
    end
    rd_idx = 4'd4;
    #1 chk("stall_rv4", 32'(a_rv), 0);

    // timeout after 10 cycles of a linear walk
    arm();
    for (int i = 0; i < 10; i++) begin
      pc = 32'(4 * i);
      tick();
    end
    rd_idx = 0;
    #1;
    chk("tmo_done", 32'(a_dn), 1);
    chk("tmo_tmo", 32'(a_to), 1);
    chk("tmo_halt", 32'(a_h), 0);
    chk("tmo_cycle", a_cyc, 10);
    chk("tmo_tcnt", 32'(a_tc), 10);
    chk("tmo_rd0", a_rd, 0);
    pc = 'h28;
    tick();
    chk("tmo_hold_cycle", a_cyc, 10);
    chk("tmo_hold_done", 32'(a_dn), 1);

    // wraparound in the 4-deep instance
    arm();
    for (int i = 0; i < 6; i++) begin
      pc = 32'(4 * i);
      tick();
    end
    chk("ovf_flag", 32'(b_ov), 1);
    chk("ovf_tcnt", 32'(b_tc), 4);
    chk("ovf_done", 32'(b_dn), 0);
    for (int i = 0; i < 4; i++) begin
      rd_idx = 4'(i);
      #1 chk($sformatf("ovf_rd%0d", i), b_rd, 32'(8 + 4 * i));
    end

    // reset in the middle of a run, then re-arm
    arm();
    for (int i = 0; i < 3; i++) begin
      pc = 32'(4 * i);
      tick();
    end
    chk("mid_cycle3", a_cyc, 3);
    rst_n = 0;
    rd_idx = 0;
    tick();
    chk("mid_rst_cycle", a_cyc, 0);
    chk("mid_rst_tcnt", 32'(a_tc), 0);
    chk("mid_rst_rv", 32'(a_rv), 0);
    rst_n = 1; en = 1;
    tick();
    chk("rearm_cycle0", a_cyc, 0);
    pc = 'h40;
    tick();
    chk("rearm_cycle1", a_cyc, 1);
    chk("rearm_tcnt", 32'(a_tc), 1);

    // en dropped mid-run keeps trace, clears flags
    arm();
    for (int i = 0; i < 3; i++) begin
      pc = 32'(4 * i);
      tick();
    end
    en = 0;
    rd_idx = 2;
    tick();
    chk("drop_cycle", a_cyc, 3);
    chk("drop_tcnt", 32'(a_tc), 3);
    chk("drop_done", 32'(a_dn), 0);
    chk("drop_rd2", a_rd, 8);

    // breakpoint on the last budgeted cycle
    arm();
    hae = 1; ha = 'h24;
    for (int i = 0; i < 10; i++) begin
      pc = 32'(4 * i);
      tick();
    end
    chk("both_halt", 32'(a_h), 1);
    chk("both_tmo", 32'(a_to), 1);
    chk("both_done", 32'(a_dn), 1);
    hae = 0;

    // random run against the model
    for (int n = 0; n < 1500; n++) begin
      rst_n = ($urandom_range(63) != 0);
      en    = ($urandom_range(7) != 0);
      if ($urandom_range(2) == 0) pc = 32'($urandom_range(7)) * 4;
      hae    = ($urandom_range(3) == 0);
      ha     = 32'($urandom_range(7)) * 4;
      rd_idx = 4'($urandom_range(15));
      tick();
      cmp(0);
      cmp(1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
